// File: rtl/rv32imf_mem_arbiter.sv
// rv32imf_mem_arbiter
// Shares one req/gnt/rvalid memory port between the instruction-fetch and
// data (LSU) interfaces of the rv32imf core. A small in-order ID queue
// remembers which requester issued each granted transaction, so every
// response can be routed back to the requester that issued it.
//
// Build option: define RV32IMF_MEM_ARB_ROUND_ROBIN_EN to switch IDLE
// arbitration from fixed priority (data > instr) to round-robin.
module rv32imf_mem_arbiter #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int ADDR_WIDTH      = 32,
   localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  instr_req_i,
   input  logic [ADDR_WIDTH-1:0] instr_addr_i,
   output logic                  instr_gnt_o,
   output logic                  instr_rvalid_o,
   output logic [31:0]           instr_rdata_o,
   input  logic                  data_req_i,
   input  logic [ADDR_WIDTH-1:0] data_addr_i,
   input  logic                  data_we_i,
   input  logic [3:0]            data_be_i,
   input  logic [31:0]           data_wdata_i,
   output logic                  data_gnt_o,
   output logic                  data_rvalid_o,
   output logic [31:0]           data_rdata_o,
   output logic                  mem_req_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic                  mem_we_o,
   output logic [3:0]            mem_be_o,
   output logic [31:0]           mem_wdata_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [31:0]           mem_rdata_i,
   output logic [CNT_W-1:0]      outstanding_o,
   output logic                  err_o
);

   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);

   // HOLD_* freezes the selection on a source whose request is waiting for gnt
   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_HOLD_DATA  = 2'd1;
   localparam logic [1:0] ST_HOLD_INSTR = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   // Queue entry: 1 = data transaction, 0 = instruction fetch
   logic             id_q [MAX_OUTSTANDING];
   logic             id_d [MAX_OUTSTANDING];
   logic             err_q, err_d;

   logic sel_data, sel_req;
   logic q_full, q_empty, block;
   logic hs, pop, head_data, err_evt;

`ifdef RV32IMF_MEM_ARB_ROUND_ROBIN_EN
   // 1 = data has priority on the next contended IDLE cycle
   logic rr_q, rr_d;
`endif

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // Source selection: frozen in HOLD, arbitrated in IDLE
   always_comb begin
      sel_data = 1'b1;
      case (state_q)
         ST_HOLD_DATA:  sel_data = 1'b1;
         ST_HOLD_INSTR: sel_data = 1'b0;
         default: begin
`ifdef RV32IMF_MEM_ARB_ROUND_ROBIN_EN
            if (data_req_i && instr_req_i) sel_data = rr_q;
            else                           sel_data = data_req_i;
`else
            sel_data = data_req_i | ~instr_req_i;
`endif
         end
      endcase
      sel_req = sel_data ? data_req_i : instr_req_i;
   end

   // Shared-port mux, handshake, and response routing
   always_comb begin
      q_full    = (cnt_q == CNT_FULL);
      q_empty   = (cnt_q == '0);
      // A response arriving this cycle frees a slot, so a full queue only
      // blocks when no rvalid is present.
      block     = q_full & ~mem_rvalid_i;
      mem_req_o = sel_req & ~block & ~rst_i;
      hs        = mem_req_o & mem_gnt_i;

      mem_addr_o  = sel_data ? data_addr_i  : instr_addr_i;
      mem_we_o    = sel_data & data_we_i;
      mem_be_o    = sel_data ? data_be_i    : 4'hF;
      mem_wdata_o = sel_data ? data_wdata_i : 32'h0;

      data_gnt_o  = hs & sel_data;
      instr_gnt_o = hs & ~sel_data;

      // The head entry belongs to an earlier grant, never this cycle's push
      pop       = mem_rvalid_i & ~q_empty & ~rst_i;
      err_evt   = mem_rvalid_i & q_empty & ~rst_i;
      head_data = id_q[rd_ptr_q];

      data_rvalid_o  = pop & head_data;
      instr_rvalid_o = pop & ~head_data;
      data_rdata_o   = (pop &  head_data) ? mem_rdata_i : 32'h0;
      instr_rdata_o  = (pop & ~head_data) ? mem_rdata_i : 32'h0;

      outstanding_o = cnt_q;
      err_o         = err_q;
   end

   // Next-state: enter HOLD on an ungranted request, leave on handshake or dropped req
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (sel_req && !hs) state_d = sel_data ? ST_HOLD_DATA : ST_HOLD_INSTR;
         end
         ST_HOLD_DATA, ST_HOLD_INSTR: begin
            if (hs || !sel_req) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ID queue push/pop bookkeeping and sticky error
   always_comb begin
      id_d     = id_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (hs) begin
         id_d[wr_ptr_q] = sel_data;
         wr_ptr_d       = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({hs, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      err_d = err_q | err_evt;
   end

`ifdef RV32IMF_MEM_ARB_ROUND_ROBIN_EN
   // Round-robin pointer moves to the source not just granted
   always_comb begin
      rr_d = rr_q;
      if (hs) rr_d = ~sel_data;
   end
`endif

   // State registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         err_q    <= 1'b0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) id_q[i] <= 1'b0;
`ifdef RV32IMF_MEM_ARB_ROUND_ROBIN_EN
         rr_q     <= 1'b1;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         err_q    <= err_d;
         id_q     <= id_d;
`ifdef RV32IMF_MEM_ARB_ROUND_ROBIN_EN
         rr_q     <= rr_d;
`endif
      end
   end

endmodule

// File: tb/tb_rv32imf_mem_arbiter.sv
// Directed testbench for rv32imf_mem_arbiter (MAX_OUTSTANDING=2).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_rv32imf_mem_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o, instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        data_req_i;
   logic [31:0] data_addr_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_wdata_i;
   logic        data_gnt_o, data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i, mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic [1:0]  outstanding_o;
   logic        err_o;

   int tests = 0;
   int fails = 0;

   always #5 clk_i = ~clk_i;

   rv32imf_mem_arbiter #(.MAX_OUTSTANDING(2), .ADDR_WIDTH(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
      .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
      .instr_rdata_o(instr_rdata_o),
      .data_req_i(data_req_i), .data_addr_i(data_addr_i),
      .data_we_i(data_we_i), .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
      .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
      .data_rdata_o(data_rdata_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .outstanding_o(outstanding_o), .err_o(err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs at the falling edge, settle 1 ns
   task automatic drv(input logic dreq, input logic [31:0] daddr, input logic dwe,
                      input logic [3:0] dbe, input logic [31:0] dwd,
                      input logic ireq, input logic [31:0] iaddr,
                      input logic gnt, input logic rv, input logic [31:0] rdata);
      @(negedge clk_i);
      data_req_i = dreq; data_addr_i = daddr; data_we_i = dwe;
      data_be_i = dbe; data_wdata_i = dwd;
      instr_req_i = ireq; instr_addr_i = iaddr;
      mem_gnt_i = gnt; mem_rvalid_i = rv; mem_rdata_i = rdata;
      #1;
   endtask

   task automatic idle();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   logic exp_data, prev_data;

   initial begin
      rst_i = 1'b1;
      data_req_i = 0; data_addr_i = 0; data_we_i = 0; data_be_i = 0; data_wdata_i = 0;
      instr_req_i = 0; instr_addr_i = 0;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
      #2;
      chk("rst_outstanding", outstanding_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_mem_req", mem_req_o, 0);
      @(negedge clk_i);
      rst_i = 1'b0;
      idle();

      // Routing: data write then instr fetch, responses in order
      drv(1, 32'h100, 1, 4'h3, 32'hDEADBEEF, 0, 32'h200, 1, 0, 0);
      chk("rt_mem_req", mem_req_o, 1);
      chk("rt_addr_d", mem_addr_o, 32'h100);
      chk("rt_we_d", mem_we_o, 1);
      chk("rt_be_d", mem_be_o, 4'h3);
      chk("rt_wdata_d", mem_wdata_o, 32'hDEADBEEF);
      chk("rt_dgnt", data_gnt_o, 1);
      chk("rt_ignt0", instr_gnt_o, 0);
      drv(0, 32'h100, 0, 4'h0, 0, 1, 32'h200, 1, 0, 0);
      chk("rt_out1", outstanding_o, 1);
      chk("rt_addr_i", mem_addr_o, 32'h200);
      chk("rt_we_i", mem_we_o, 0);
      chk("rt_be_i", mem_be_o, 4'hF);
      chk("rt_wdata_i", mem_wdata_o, 0);
      chk("rt_ignt", instr_gnt_o, 1);
      chk("rt_dgnt0", data_gnt_o, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h11111111);
      chk("rt_out2", outstanding_o, 2);
      chk("rt_drv1", data_rvalid_o, 1);
      chk("rt_drd1", data_rdata_o, 32'h11111111);
      chk("rt_irv1", instr_rvalid_o, 0);
      chk("rt_ird1", instr_rdata_o, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h22222222);
      chk("rt_out3", outstanding_o, 1);
      chk("rt_irv2", instr_rvalid_o, 1);
      chk("rt_ird2", instr_rdata_o, 32'h22222222);
      chk("rt_drv2", data_rvalid_o, 0);
      chk("rt_drd2", data_rdata_o, 0);
      idle();
      chk("rt_out0", outstanding_o, 0);
      chk("rt_err0", err_o, 0);

      // Full queue: two data grants, then instr blocked until an rvalid
      drv(1, 32'h10, 0, 4'hF, 0, 0, 0, 1, 0, 0);
      drv(1, 32'h14, 0, 4'hF, 0, 0, 0, 1, 0, 0);
      drv(0, 0, 0, 0, 0, 1, 32'h700, 1, 0, 0);
      chk("fq_out2", outstanding_o, 2);
      chk("fq_blocked_req", mem_req_o, 0);
      chk("fq_blocked_gnt", instr_gnt_o, 0);
      drv(0, 0, 0, 0, 0, 1, 32'h700, 1, 1, 32'hAAAA0001);
      chk("fq_out_still2", outstanding_o, 2);
      chk("fq_req", mem_req_o, 1);
      chk("fq_ignt", instr_gnt_o, 1);
      chk("fq_drv", data_rvalid_o, 1);
      chk("fq_drd", data_rdata_o, 32'hAAAA0001);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA0002);
      chk("fq_out_after", outstanding_o, 2);
      chk("fq_drv2", data_rvalid_o, 1);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA0003);
      chk("fq_irv", instr_rvalid_o, 1);
      chk("fq_ird", instr_rdata_o, 32'hAAAA0003);
      idle();
      chk("fq_out0", outstanding_o, 0);

      // Hold: instr waits 3 cycles, data raised in cycle 2 must not steal the port
      drv(0, 32'h400, 0, 4'hF, 0, 1, 32'h300, 0, 0, 0);
      chk("hd_addr1", mem_addr_o, 32'h300);
      chk("hd_ignt1", instr_gnt_o, 0);
      drv(1, 32'h400, 0, 4'hF, 0, 1, 32'h300, 0, 0, 0);
      chk("hd_addr2", mem_addr_o, 32'h300);
      chk("hd_dgnt2", data_gnt_o, 0);
      drv(1, 32'h400, 0, 4'hF, 0, 1, 32'h300, 0, 0, 0);
      chk("hd_addr3", mem_addr_o, 32'h300);
      drv(1, 32'h400, 0, 4'hF, 0, 1, 32'h300, 1, 0, 0);
      chk("hd_addr4", mem_addr_o, 32'h300);
      chk("hd_ignt4", instr_gnt_o, 1);
      chk("hd_dgnt4", data_gnt_o, 0);
      drv(1, 32'h400, 0, 4'hF, 0, 0, 32'h300, 1, 0, 0);
      chk("hd_addr5", mem_addr_o, 32'h400);
      chk("hd_dgnt5", data_gnt_o, 1);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h33);
      chk("hd_irv", instr_rvalid_o, 1);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h44);
      chk("hd_drv", data_rvalid_o, 1);
      chk("hd_drd", data_rdata_o, 32'h44);

      // Reset mid-transfer with 2 outstanding
      drv(1, 32'h20, 0, 4'hF, 0, 0, 0, 1, 0, 0);
      drv(1, 32'h24, 0, 4'hF, 0, 0, 0, 1, 0, 0);
      drv(1, 32'h28, 0, 4'hF, 0, 1, 32'h800, 1, 1, 32'h55);
      chk("mr_pre_out", outstanding_o, 2);
      rst_i = 1'b1;
      #1;
      chk("mr_out", outstanding_o, 0);
      chk("mr_err", err_o, 0);
      chk("mr_req", mem_req_o, 0);
      chk("mr_dgnt", data_gnt_o, 0);
      chk("mr_ignt", instr_gnt_o, 0);
      chk("mr_drv", data_rvalid_o, 0);
      chk("mr_irv", instr_rvalid_o, 0);
      idle();
      rst_i = 1'b0;

      // Contention right after reset: both request every cycle, rvalid one cycle later
      prev_data = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drv(1, 32'h500 + 32'(k * 4), 0, 4'hF, 0, 1, 32'h600, 1, (k > 0), 32'hC0 + 32'(k));
`ifdef RV32IMF_MEM_ARB_ROUND_ROBIN_EN
         exp_data = ((k % 2) == 0);
`else
         exp_data = 1'b1;
`endif
         chk("ct_dgnt", data_gnt_o, exp_data);
         chk("ct_ignt", instr_gnt_o, !exp_data);
         if (k > 0) begin
            chk("ct_drv", data_rvalid_o, prev_data);
            chk("ct_irv", instr_rvalid_o, !prev_data);
            chk("ct_drd", data_rdata_o, prev_data ? 32'hC0 + 32'(k) : 32'h0);
            chk("ct_out", outstanding_o, 1);
         end
         prev_data = exp_data;
      end
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hC4);
      chk("ct_last_drv", data_rvalid_o, prev_data);
      chk("ct_last_irv", instr_rvalid_o, !prev_data);
      idle();
      chk("ct_out0", outstanding_o, 0);

      // Error: rvalid with an empty queue
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h99);
      chk("er_drv", data_rvalid_o, 0);
      chk("er_irv", instr_rvalid_o, 0);
      chk("er_drd", data_rdata_o, 0);
      idle();
      chk("er_set", err_o, 1);
      chk("er_out", outstanding_o, 0);
      drv(1, 32'h40, 0, 4'hF, 0, 0, 0, 1, 0, 0);
      chk("er_dgnt", data_gnt_o, 1);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77);
      chk("er_drv2", data_rvalid_o, 1);
      chk("er_sticky1", err_o, 1);
      idle();
      chk("er_sticky2", err_o, 1);
      chk("er_out_end", outstanding_o, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
